// File: rtl/lfsr_prbs_checker.sv
// -----------------------------------------------------------------------------
// lfsr_prbs_checker
//
// Receive-side checker for the 8-bit LFSR pattern generator. It
// self-synchronises to an incoming parallel stream of LFSR states. It then runs
// its own copy of the LFSR and flags every received word that differs from the
// prediction. Mismatches seen while locked go into a saturating error counter,
// and a pass/fail verdict is reported.
//
// Step function: nxt(s) = {s[WIDTH-2:0], ^(s & TAPS)}
//
// States
//   IDLE   : waiting for the first non-zero word to seed the prediction
//   SYNC   : reseeding on every word, counting consecutive correct predictions
//   LOCKED : prediction free-runs; mismatches are errors
//   LOST   : one enabled cycle used to reseed after lock was dropped
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous, active-high reset
//   enable     in   1      data_in valid this cycle; low = hold all state
//   clr        in   1      synchronous clear of err_count (other state kept)
//   data_in    in   WIDTH  received LFSR state word
//   locked     out  1      checker is in LOCKED (registered)
//   error      out  1      one-cycle pulse: mismatch detected in LOCKED
//   err_count  out  CNT_W  saturating count of LOCKED mismatches
//   pass_fail  out  1      1 = locked && err_count == 0
// -----------------------------------------------------------------------------
module lfsr_prbs_checker #(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] TAPS     = 8'hB8,
    parameter int unsigned      LOCK_CNT = 4,
    parameter int unsigned      BAD_CNT  = 3,
    parameter int unsigned      CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clr,
    input  logic [WIDTH-1:0] data_in,
    output logic             locked,
    output logic             error,
    output logic [CNT_W-1:0] err_count,
    output logic             pass_fail
);

    // The run-length counters only need to reach their targets.
    localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned BAD_W  = $clog2(BAD_CNT + 1);

    localparam logic [GOOD_W-1:0] LOCK_TGT = GOOD_W'(LOCK_CNT);
    localparam logic [BAD_W-1:0]  BAD_TGT  = BAD_W'(BAD_CNT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2,
        ST_LOST   = 2'd3
    } state_e;

    function automatic logic [WIDTH-1:0] lfsr_nxt(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], ^(s & TAPS)};
    endfunction

    state_e             state_q,     state_d;
    logic [WIDTH-1:0]   expected_q,  expected_d;
    logic [GOOD_W-1:0]  good_cnt_q,  good_cnt_d;
    logic [BAD_W-1:0]   bad_cnt_q,   bad_cnt_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;
    logic               error_q,     error_d;
    logic               locked_q,    locked_d;

    logic               data_match;
    logic [GOOD_W-1:0]  good_inc;
    logic [BAD_W-1:0]   bad_inc;
    logic               err_sat;

    // The all-zero word is the LFSR lock-up state, so it never counts as a
    // match. A healthy prediction is never zero, but the explicit term keeps
    // the rule independent of that property.
    assign data_match = (data_in == expected_q) && (data_in != '0);
    assign good_inc   = good_cnt_q + GOOD_W'(1);
    assign bad_inc    = bad_cnt_q + BAD_W'(1);
    assign err_sat    = &err_count_q;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        expected_d  = expected_q;
        good_cnt_d  = good_cnt_q;
        bad_cnt_d   = bad_cnt_q;
        err_count_d = err_count_q;
        error_d     = 1'b0;

        if (enable) begin
            unique case (state_q)
                ST_IDLE: begin
                    // A zero word cannot seed a useful prediction.
                    if (data_in != '0) begin
                        expected_d = lfsr_nxt(data_in);
                        good_cnt_d = '0;
                        state_d    = ST_SYNC;
                    end
                end

                ST_SYNC: begin
                    // Always reseed from the received word, so the checker
                    // follows whatever the stream is doing until a run of
                    // correct predictions proves it is a clean LFSR sequence.
                    expected_d = lfsr_nxt(data_in);
                    if (data_match) begin
                        if (good_inc == LOCK_TGT) begin
                            good_cnt_d = '0;
                            bad_cnt_d  = '0;
                            state_d    = ST_LOCKED;
                        end else begin
                            good_cnt_d = good_inc;
                        end
                    end else begin
                        good_cnt_d = '0;
                    end
                end

                ST_LOCKED: begin
                    // The prediction free-runs, so a single corrupted word
                    // cannot derail the words that follow it.
                    expected_d = lfsr_nxt(expected_q);
                    if (data_match) begin
                        bad_cnt_d = '0;
                    end else begin
                        error_d = 1'b1;
                        if (!err_sat) begin
                            err_count_d = err_count_q + CNT_W'(1);
                        end
                        // The mismatch that drops lock is still counted above.
                        if (bad_inc == BAD_TGT) begin
                            bad_cnt_d = '0;
                            state_d   = ST_LOST;
                        end else begin
                            bad_cnt_d = bad_inc;
                        end
                    end
                end

                ST_LOST: begin
                    expected_d = lfsr_nxt(data_in);
                    good_cnt_d = '0;
                    state_d    = ST_SYNC;
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // A clear is honoured even when enable is low. It also wins over an
        // increment in the same cycle.
        if (clr) begin
            err_count_d = '0;
        end

        // locked is registered alongside the state. It rises on the edge that
        // samples the final lock match and falls on the edge that enters LOST.
        locked_d = (state_d == ST_LOCKED);
    end

    // NOTE: sequential state is updated only with non-blocking assignments,
    // so every flop samples the values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            expected_q  <= '0;
            good_cnt_q  <= '0;
            bad_cnt_q   <= '0;
            err_count_q <= '0;
            error_q     <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            good_cnt_q  <= good_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
            err_count_q <= err_count_d;
            error_q     <= error_d;
            locked_q    <= locked_d;
        end
    end

    assign locked    = locked_q;
    assign error     = error_q;
    assign err_count = err_count_q;
    assign pass_fail = locked_q && (err_count_q == '0);

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// -----------------------------------------------------------------------------
// tb_lfsr_prbs_checker
//
// Drives two checkers from the same stimulus: one with default parameters and
// one with CNT_W=4, which makes counter saturation quick to reach. The bench
// keeps its own model of the link: a transmit LFSR and an abstract checker
// model that follows the behavioural rules word by word. All outputs of both
// instances are compared with the model after every clock. Scenario tasks add
// directed checks at the points of interest.
// -----------------------------------------------------------------------------
module tb_lfsr_prbs_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        clr;
    logic [7:0]  data_in;

    logic        locked0, error0, pass_fail0;
    logic [15:0] err_count0;
    logic        locked1, error1, pass_fail1;
    logic [3:0]  err_count1;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    lfsr_prbs_checker dut (
        .clk(clk), .rst(rst), .enable(enable), .clr(clr), .data_in(data_in),
        .locked(locked0), .error(error0), .err_count(err_count0),
        .pass_fail(pass_fail0)
    );

    lfsr_prbs_checker #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .enable(enable), .clr(clr), .data_in(data_in),
        .locked(locked1), .error(error1), .err_count(err_count1),
        .pass_fail(pass_fail1)
    );

    // ---------------- reference model ----------------
    localparam int M_IDLE = 0, M_SYNC = 1, M_LOCKED = 2, M_LOST = 3;
    localparam int LOCK_RUN = 4, BAD_RUN = 3;

    int m_mode [2];
    int m_pred [2];
    int m_good [2];
    int m_bad  [2];
    int m_errc [2];
    int m_err  [2];
    int m_max  [2] = '{65535, 15};

    int tx;  // transmitter LFSR state

    // Next LFSR state: shift left and bring in the parity of the tapped bits.
    function automatic int lfsr_next(input int s);
        int fb;
        fb = $countones(s & 'hB8) % 2;
        return ((s * 2) % 256) + fb;
    endfunction

    function automatic void model_step(input int k, input bit r, input bit en,
                                       input bit c, input int d);
        int flag;
        flag = 0;
        if (r) begin
            m_mode[k] = M_IDLE; m_pred[k] = 0; m_good[k] = 0;
            m_bad[k]  = 0;      m_errc[k] = 0; m_err[k]  = 0;
            return;
        end
        if (en) begin
            if (m_mode[k] == M_IDLE) begin
                if (d != 0) begin
                    m_pred[k] = lfsr_next(d); m_good[k] = 0; m_mode[k] = M_SYNC;
                end
            end else if (m_mode[k] == M_SYNC) begin
                if (d == m_pred[k] && d != 0) m_good[k] = m_good[k] + 1;
                else                          m_good[k] = 0;
                m_pred[k] = lfsr_next(d);
                if (m_good[k] == LOCK_RUN) begin
                    m_mode[k] = M_LOCKED; m_bad[k] = 0; m_good[k] = 0;
                end
            end else if (m_mode[k] == M_LOCKED) begin
                if (d != m_pred[k]) begin
                    flag = 1;
                    if (m_errc[k] < m_max[k]) m_errc[k] = m_errc[k] + 1;
                    m_bad[k] = m_bad[k] + 1;
                    if (m_bad[k] == BAD_RUN) begin
                        m_mode[k] = M_LOST; m_bad[k] = 0;
                    end
                end else begin
                    m_bad[k] = 0;
                end
                m_pred[k] = lfsr_next(m_pred[k]);
            end else begin
                m_pred[k] = lfsr_next(d); m_good[k] = 0; m_mode[k] = M_SYNC;
            end
        end
        if (c) m_errc[k] = 0;
        m_err[k] = flag;
    endfunction

    // One clock: drive on the falling edge, then after the rising edge advance
    // the model and compare every output of both instances.
    task automatic apply(input bit en, input bit c, input bit r, input int d);
        bit exp_lock0, exp_lock1;
        @(negedge clk);
        enable  = en;
        clr     = c;
        rst     = r;
        data_in = d[7:0];
        @(posedge clk);
        #1;
        model_step(0, r, en, c, d);
        model_step(1, r, en, c, d);
        exp_lock0 = (m_mode[0] == M_LOCKED);
        exp_lock1 = (m_mode[1] == M_LOCKED);

        compared++;
        if (locked0 !== exp_lock0) begin
            mismatched++;
            $display("FAIL model_locked t=%0t: got %0b want %0b", $time, locked0, exp_lock0);
        end
        compared++;
        if (error0 !== 1'(m_err[0])) begin
            mismatched++;
            $display("FAIL model_error t=%0t: got %0b want %0d", $time, error0, m_err[0]);
        end
        compared++;
        if (err_count0 !== 16'(m_errc[0])) begin
            mismatched++;
            $display("FAIL model_err_count t=%0t: got %0d want %0d", $time, err_count0, m_errc[0]);
        end
        compared++;
        if (pass_fail0 !== (exp_lock0 && m_errc[0] == 0)) begin
            mismatched++;
            $display("FAIL model_pass_fail t=%0t: got %0b", $time, pass_fail0);
        end
        compared++;
        if (locked1 !== exp_lock1) begin
            mismatched++;
            $display("FAIL model4_locked t=%0t: got %0b want %0b", $time, locked1, exp_lock1);
        end
        compared++;
        if (error1 !== 1'(m_err[1])) begin
            mismatched++;
            $display("FAIL model4_error t=%0t: got %0b want %0d", $time, error1, m_err[1]);
        end
        compared++;
        if (err_count1 !== 4'(m_errc[1])) begin
            mismatched++;
            $display("FAIL model4_err_count t=%0t: got %0d want %0d", $time, err_count1, m_errc[1]);
        end
        compared++;
        if (pass_fail1 !== (exp_lock1 && m_errc[1] == 0)) begin
            mismatched++;
            $display("FAIL model4_pass_fail t=%0t: got %0b", $time, pass_fail1);
        end
    endtask

    task automatic send_clean();
        apply(1'b1, 1'b0, 1'b0, tx);
        tx = lfsr_next(tx);
    endtask

    // Word that is guaranteed to differ from what the transmitter sends now.
    task automatic send_garbage();
        int g;
        g = int'($urandom_range(0, 255));
        while (g == tx) g = int'($urandom_range(0, 255));
        apply(1'b1, 1'b0, 1'b0, g);
        tx = lfsr_next(tx);
    endtask

    task automatic do_reset();
        apply(1'b1, 1'b0, 1'b1, int'($urandom_range(0, 255)));
    endtask

    function automatic int random_seed();
        return int'($urandom_range(1, 255));
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        do_reset();
        compared++;
        if (locked0 !== 1'b0 || error0 !== 1'b0 || err_count0 !== 16'd0 || pass_fail0 !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_outputs: locked=%0b error=%0b cnt=%0d pf=%0b want all 0",
                     locked0, error0, err_count0, pass_fail0);
        end
        compared++;
        if (locked1 !== 1'b0 || err_count1 !== 4'd0) begin
            mismatched++;
            $display("FAIL reset_outputs4: locked=%0b cnt=%0d want 0", locked1, err_count1);
        end
    endtask

    task automatic test_lock_clean();
        do_reset();
        tx = 1;
        for (int i = 0; i < 4; i++) send_clean();
        compared++;
        if (locked0 !== 1'b0) begin
            mismatched++;
            $display("FAIL lock_early: locked=%0b after 4 words, want 0", locked0);
        end
        send_clean();  // 8'h11, the fifth word
        compared++;
        if (locked0 !== 1'b1 || pass_fail0 !== 1'b1 || err_count0 !== 16'd0) begin
            mismatched++;
            $display("FAIL lock_at_5th: locked=%0b pf=%0b cnt=%0d want 1/1/0",
                     locked0, pass_fail0, err_count0);
        end
    endtask

    task automatic test_single_error();
        send_clean();
        apply(1'b1, 1'b0, 1'b0, tx ^ 1);  // bit0 flipped
        tx = lfsr_next(tx);
        compared++;
        if (error0 !== 1'b1 || err_count0 !== 16'd1 || locked0 !== 1'b1) begin
            mismatched++;
            $display("FAIL single_err: error=%0b cnt=%0d locked=%0b want 1/1/1",
                     error0, err_count0, locked0);
        end
        send_clean();
        compared++;
        if (error0 !== 1'b0 || locked0 !== 1'b1) begin
            mismatched++;
            $display("FAIL single_err_pulse: error=%0b locked=%0b want 0/1", error0, locked0);
        end
        for (int i = 0; i < 6; i++) send_clean();
        compared++;
        if (err_count0 !== 16'd1 || pass_fail0 !== 1'b0) begin
            mismatched++;
            $display("FAIL single_err_after: cnt=%0d pf=%0b want 1/0", err_count0, pass_fail0);
        end
    endtask

    task automatic test_lock_loss();
        do_reset();
        tx = random_seed();
        for (int i = 0; i < 5; i++) send_clean();
        for (int i = 0; i < 3; i++) send_garbage();
        compared++;
        if (locked0 !== 1'b0 || err_count0 !== 16'd3) begin
            mismatched++;
            $display("FAIL lost_lock: locked=%0b cnt=%0d want 0/3", locked0, err_count0);
        end
        for (int i = 0; i < 4; i++) send_clean();
        compared++;
        if (locked0 !== 1'b0) begin
            mismatched++;
            $display("FAIL relock_early: locked=%0b want 0", locked0);
        end
        send_clean();
        compared++;
        if (locked0 !== 1'b1 || err_count0 !== 16'd3 || pass_fail0 !== 1'b0) begin
            mismatched++;
            $display("FAIL relock: locked=%0b cnt=%0d pf=%0b want 1/3/0",
                     locked0, err_count0, pass_fail0);
        end
    endtask

    task automatic test_zero_hold();
        do_reset();
        for (int i = 0; i < 20; i++) apply(1'b1, 1'b0, 1'b0, 0);
        compared++;
        if (locked0 !== 1'b0 || err_count0 !== 16'd0) begin
            mismatched++;
            $display("FAIL zero_hold: locked=%0b cnt=%0d want 0/0", locked0, err_count0);
        end
        tx = random_seed();
        for (int i = 0; i < 5; i++) send_clean();
        compared++;
        if (locked0 !== 1'b1) begin
            mismatched++;
            $display("FAIL zero_then_lock: locked=%0b want 1", locked0);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        tx = random_seed();
        for (int i = 0; i < 5; i++) send_clean();
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) begin
                apply(1'b1, 1'b0, 1'b0, tx ^ 'h80);
                tx = lfsr_next(tx);
            end else begin
                send_clean();
            end
        end
        compared++;
        if (err_count1 !== 4'd15 || locked1 !== 1'b1) begin
            mismatched++;
            $display("FAIL sat_cnt4: cnt=%0d locked=%0b want 15/1", err_count1, locked1);
        end
        compared++;
        if (err_count0 !== 16'd20) begin
            mismatched++;
            $display("FAIL sat_cnt16: cnt=%0d want 20", err_count0);
        end
        apply(1'b1, 1'b1, 1'b0, tx ^ 'h80);  // clear together with a bad word
        tx = lfsr_next(tx);
        compared++;
        if (err_count1 !== 4'd0 || err_count0 !== 16'd0 || error0 !== 1'b1) begin
            mismatched++;
            $display("FAIL clr_priority: cnt4=%0d cnt=%0d error=%0b want 0/0/1",
                     err_count1, err_count0, error0);
        end
    endtask

    task automatic test_enable_and_reset();
        do_reset();
        tx = random_seed();
        for (int i = 0; i < 5; i++) send_clean();
        for (int i = 0; i < 5; i++) apply(1'b0, 1'b0, 1'b0, int'($urandom_range(0, 255)));
        for (int i = 0; i < 6; i++) send_clean();
        compared++;
        if (err_count0 !== 16'd0 || locked0 !== 1'b1) begin
            mismatched++;
            $display("FAIL enable_hold: cnt=%0d locked=%0b want 0/1", err_count0, locked0);
        end
        apply(1'b1, 1'b0, 1'b0, tx ^ 1);
        tx = lfsr_next(tx);
        apply(1'b1, 1'b0, 1'b1, tx ^ 1);  // reset while a bad word arrives
        compared++;
        if (locked0 !== 1'b0 || err_count0 !== 16'd0 || error0 !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_locked: locked=%0b cnt=%0d error=%0b want 0/0/0",
                     locked0, err_count0, error0);
        end
    endtask

    task automatic test_random();
        int burst;
        do_reset();
        tx = random_seed();
        burst = 0;
        for (int i = 0; i < 3000; i++) begin
            bit en, c, r;
            en = ($urandom_range(0, 99) < 85);
            c  = ($urandom_range(0, 99) < 3);
            r  = ($urandom_range(0, 999) < 5);
            if (burst == 0 && $urandom_range(0, 99) < 5) burst = int'($urandom_range(1, 4));
            if (!en) begin
                apply(1'b0, c, r, int'($urandom_range(0, 255)));
            end else if (burst > 0) begin
                apply(1'b1, c, r, int'($urandom_range(0, 255)));
                tx = lfsr_next(tx);
                burst--;
            end else begin
                apply(1'b1, c, r, tx);
                tx = lfsr_next(tx);
            end
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; clr = 1'b0; data_in = '0;
        tx = 1;
        test_reset();
        test_lock_clean();
        test_single_error();
        test_lock_loss();
        test_zero_hold();
        test_saturation();
        test_enable_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
